// File: rtl/cg_inverse_scan_table.sv
// Inverse CG scan table: builds table[pos] = idx from the forward scan,
// then answers registered position-to-index lookups.
module cg_inverse_scan_table #(
    parameter int NUM_POS = 64,
    parameter int IDX_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       log2WidthInGroups,
    input  logic [1:0]       log2HeightInGroups,
    output logic             busy,
    output logic             done,
    input  logic             lkp_valid,
    input  logic [5:0]       lkp_pos,
    output logic             lkp_ready,
    output logic             rsp_valid,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, BUILD, READY} state_t;

    state_t             state_q, state_d;
    logic [1:0]         lw_q, lw_d, lh_q, lh_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         s_q, s_d;
    logic [2:0]         j_q, j_d;
    logic [NUM_POS-1:0] vld_q, vld_d;
    logic [IDX_W-1:0]   tbl_q [NUM_POS];
    logic [IDX_W-1:0]   tbl_d [NUM_POS];
    logic               done_q, done_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic               rsp_err_q, rsp_err_d;

    logic [IDX_W-1:0]   n_last;
    logic [5:0]         wr_pos;
    logic [5:0]         diag_pos;
    logic [3:0]         jz, jmax, x4, y4;
    logic               last, accept;

    // Anti-diagonal walk of the 8x8 grid, direction alternating per diagonal
    always_comb begin
        jz   = {1'b0, j_q};
        jmax = (s_q < 4'd8) ? s_q : 4'd14 - s_q;
        x4   = '0;
        y4   = '0;
        if (s_q < 4'd8) begin
            if (!s_q[0]) begin
                x4 = s_q - jz;
                y4 = jz;
            end else begin
                x4 = jz;
                y4 = s_q - jz;
            end
        end else begin
            if (!s_q[0]) begin
                x4 = 4'd7 - jz;
                y4 = s_q - 4'd7 + jz;
            end else begin
                x4 = s_q - 4'd7 + jz;
                y4 = 4'd7 - jz;
            end
        end
        diag_pos = {x4[2:0], y4[2:0]};
    end

    always_comb begin
        n_last = IDX_W'(63);
        wr_pos = idx_q[5:0];
        if (lw_q == lh_q) begin
            case (lw_q)
                2'd0: begin
                    n_last = IDX_W'(0);
                    wr_pos = 6'd0;
                end
                2'd1: begin
                    n_last = IDX_W'(3);
                    wr_pos = {4'd0, idx_q[1], idx_q[1] ^ idx_q[0]};
                end
                2'd2: begin
                    n_last = IDX_W'(15);
                    wr_pos = {2'd0, idx_q[3], idx_q[1], idx_q[2], idx_q[0]};
                end
                default: begin
                    n_last = IDX_W'(63);
                    wr_pos = diag_pos;
                end
            endcase
        end
    end

    assign last   = (idx_q == n_last);
    assign accept = lkp_valid && (state_q == READY) && !start;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = BUILD;
        end else if (state_q == BUILD && last) begin
            state_d = READY;
        end
    end

    always_comb begin
        lw_d        = lw_q;
        lh_d        = lh_q;
        idx_d       = idx_q;
        s_d         = s_q;
        j_d         = j_q;
        vld_d       = vld_q;
        tbl_d       = tbl_q;
        done_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_idx_d   = '0;
        rsp_err_d   = 1'b0;
        if (start) begin
            lw_d  = log2WidthInGroups;
            lh_d  = log2HeightInGroups;
            vld_d = '0;
            idx_d = '0;
            s_d   = '0;
            j_d   = '0;
        end else if (state_q == BUILD) begin
            tbl_d[wr_pos] = idx_q;
            vld_d[wr_pos] = 1'b1;
            idx_d         = idx_q + IDX_W'(1);
            done_d        = last;
            if (j_q == jmax[2:0]) begin
                s_d = s_q + 4'd1;
                j_d = '0;
            end else begin
                j_d = j_q + 3'd1;
            end
        end
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !vld_q[lkp_pos];
            rsp_idx_d   = vld_q[lkp_pos] ? tbl_q[lkp_pos] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lw_q        <= '0;
            lh_q        <= '0;
            idx_q       <= '0;
            s_q         <= '0;
            j_q         <= '0;
            vld_q       <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lw_q        <= lw_d;
            lh_q        <= lh_d;
            idx_q       <= idx_d;
            s_q         <= s_d;
            j_q         <= j_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Entries are qualified by vld_q, so the data array needs no reset
    always_ff @(posedge clk) begin
        tbl_q <= tbl_d;
    end

    always_comb begin
        busy      = (state_q == BUILD);
        lkp_ready = (state_q == READY);
        done      = done_q;
        rsp_valid = rsp_valid_q;
        rsp_idx   = rsp_idx_q;
        rsp_err   = rsp_err_q;
    end

endmodule

// File: tb/tb_cg_inverse_scan_table.sv
// Scoreboard bench for cg_inverse_scan_table: directed builds and lookups.
module tb_cg_inverse_scan_table;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] lw = 2'd0;
    logic [1:0] lh = 2'd0;
    logic       busy, done;
    logic       lkp_valid = 1'b0;
    logic [5:0] lkp_pos = 6'd0;
    logic       lkp_ready, rsp_valid;
    logic [6:0] rsp_idx;
    logic       rsp_err;

    cg_inverse_scan_table dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .log2WidthInGroups  (lw),
        .log2HeightInGroups (lh),
        .busy               (busy),
        .done               (done),
        .lkp_valid          (lkp_valid),
        .lkp_pos            (lkp_pos),
        .lkp_ready          (lkp_ready),
        .rsp_valid          (rsp_valid),
        .rsp_idx            (rsp_idx),
        .rsp_err            (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pos;
        int idx;
        int err;
        int cyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp got=1 exp=0 idx=%0d cyc=%0d",
                         rsp_idx, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("rsp_idx pos%0d", e.pos), rsp_idx, e.idx);
                check($sformatf("rsp_err pos%0d", e.pos), rsp_err, e.err);
                check($sformatf("rsp_cyc pos%0d", e.pos), cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [1:0] w, input logic [1:0] h,
                         input int n, input string name);
        int t0, first_done, busy_cnt;
        start = 1'b1;
        lw = w;
        lh = h;
        t0 = cyc;
        tick();
        start = 1'b0;
        lkp_valid = 1'b0;
        check({name, "_ready_drop"}, lkp_ready, 0);
        first_done = -1;
        busy_cnt = 0;
        for (int i = 0; i < 200 && first_done < 0; i++) begin
            if (busy) busy_cnt++;
            if (done) first_done = cyc;
            else tick();
        end
        check({name, "_done_cyc"}, first_done, t0 + n + 1);
        check({name, "_busy_cnt"}, busy_cnt, n);
        check({name, "_ready"}, lkp_ready, 1);
        tick();
        check({name, "_done_pulse"}, done, 0);
    endtask

    task automatic lookup(input int pos, input int ei, input int ee,
                          input bit acc);
        lkp_valid = 1'b1;
        lkp_pos = 6'(pos);
        if (acc) q.push_back('{pos, ei, ee, cyc + 1});
        tick();
        lkp_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        check({name, "_q_empty"}, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int dcnt;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_idx", rsp_idx, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_ready", lkp_ready, 0);
        rst_n = 1'b1;
        tick();

        check("idle_ready", lkp_ready, 0);
        lookup(0, 0, 0, 0);
        drain("idle");

        build(2'd3, 2'd3, 64, "b8x8");
        lookup(0, 0, 0, 1);
        lookup(1, 1, 0, 1);
        lookup(8, 2, 0, 1);
        lookup(16, 3, 0, 1);
        lookup(9, 4, 0, 1);
        lookup(2, 5, 0, 1);
        lookup(7, 28, 0, 1);
        lookup(56, 35, 0, 1);
        lookup(63, 63, 0, 1);
        drain("l8x8");

        // start races a lookup in READY: start wins, no response
        lkp_valid = 1'b1;
        lkp_pos = 6'd0;
        build(2'd1, 2'd1, 4, "b2x2");
        lookup(3, 2, 0, 1);
        lookup(2, 3, 0, 1);
        lookup(4, 0, 1, 1);
        lookup(1, 1, 0, 1);
        drain("l2x2");

        build(2'd2, 2'd2, 16, "b4x4");
        lookup(4, 2, 0, 1);
        lookup(2, 4, 0, 1);
        lookup(15, 15, 0, 1);
        lookup(12, 10, 0, 1);
        lookup(20, 0, 1, 1);
        drain("l4x4");

        build(2'd0, 2'd0, 1, "b1x1");
        lookup(0, 0, 0, 1);
        lookup(5, 0, 1, 1);
        drain("l1x1");

        build(2'd3, 2'd1, 64, "brect");
        lookup(37, 37, 0, 1);
        lookup(63, 63, 0, 1);
        lookup(0, 0, 0, 1);
        drain("lrect");

        start = 1'b1;
        lw = 2'd3;
        lh = 2'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        build(2'd3, 2'd3, 64, "restart");
        lookup(8, 2, 0, 1);
        lookup(63, 63, 0, 1);
        drain("lrestart");

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", lkp_ready, 0);
        lookup(0, 0, 0, 0);
        dcnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) dcnt++;
            tick();
        end
        check("midrst_no_done", dcnt, 0);
        check("midrst_ready_late", lkp_ready, 0);
        drain("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
